mms_stream_acc: RTL and testbench



---
 rtl/mms_stream_acc_if.sv | 25 ++
 rtl/mms_stream_acc.sv | 117 +++++++++++
 tb/tb_mms_stream_acc.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mms_stream_acc_if.sv
// Producer/consumer handshake bundle for the streaming max/min selector.
// The slave modport is the selector; the master modport is the producer and consumer side.
interface mms_stream_acc_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic             select;
  logic [WIDTH-1:0] number;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [IDX_W-1:0] index;

  modport slave (
    input  in_valid, select, number, out_ready,
    output in_ready, out_valid, result, index
  );

  modport master (
    output in_valid, select, number, out_ready,
    input  in_ready, out_valid, result, index
  );
endinterface

// File: rtl/mms_stream_acc.sv
// Streaming max/min selector: reduces each FRAME-number frame to its maximum or minimum
// and the 0-based position of that element, handed off over a valid/ready handshake.
module mms_stream_acc #(
  parameter int WIDTH = 8,
  parameter int FRAME = 4,
  parameter int IDX_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  mms_stream_acc_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [IDX_W-1:0] bidx_q, bidx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic accept;
  logic handoff;
  logic replace;

  assign accept  = bus.in_valid & in_ready_q;
  assign handoff = out_valid_q & bus.out_ready;
  // Strict compare keeps the earliest occurrence on ties.
  assign replace = mode_q ? (bus.number < best_q) : (bus.number > best_q);

  always_comb begin
    state_d     = state_q;
    best_d      = best_q;
    bidx_d      = bidx_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    result_d    = result_q;
    index_d     = index_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          best_d  = bus.number;
          bidx_d  = '0;
          mode_d  = bus.select;
          cnt_d   = IDX_W'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (replace) begin
            best_d = bus.number;
            bidx_d = cnt_q;
          end
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == LAST) begin
            result_d    = replace ? bus.number : best_q;
            index_d     = replace ? cnt_q : bidx_q;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (handoff) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      best_q      <= '0;
      bidx_q      <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      result_q    <= '0;
      index_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      best_q      <= best_d;
      bidx_q      <= bidx_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      result_q    <= result_d;
      index_q     <= index_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.index     = index_q;

endmodule

// File: tb/tb_mms_stream_acc.sv
// Directed bench for mms_stream_acc: hand-computed frame results, hold/backpressure,
// mid-frame reset, bubbles and back-to-back frames.
module tb_mms_stream_acc;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  mms_stream_acc_if #(.WIDTH(8), .IDX_W(2)) bus ();

  mms_stream_acc #(.WIDTH(8), .FRAME(4), .IDX_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one beat and waits (bounded) until the DUT takes it.
  task automatic send(input logic [7:0] n, input logic sel, input string tag);
    int waited;
    bus.in_valid = 1'b1;
    bus.number   = n;
    bus.select   = sel;
    waited       = 0;
    while (!bus.in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.number   = 8'($urandom);
    bus.select   = 1'($urandom);
  endtask

  task automatic frame(input string tag, input logic [3:0] sels,
                       input logic [7:0] n0, input logic [7:0] n1,
                       input logic [7:0] n2, input logic [7:0] n3,
                       input int er, input int ei, input bit gaps, input int hold);
    logic [7:0] nums [4];
    nums = '{n0, n1, n2, n3};
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      send(nums[i], sels[i], tag);
    end
    chk({tag, "_latency_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_result"}, 32'(bus.result), 32'(er));
    chk({tag, "_index"}, 32'(bus.index), 32'(ei));
    chk({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
    for (int c = 0; c < hold; c++) begin
      bus.in_valid  = 1'b1;
      bus.number    = 8'd77;
      bus.out_ready = 1'b0;
      tick();
      chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_result"}, 32'(bus.result), 32'(er));
      chk({tag, "_hold_index"}, 32'(bus.index), 32'(ei));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk({tag, "_handoff_valid_low"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_handoff_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_result"}, 32'(bus.result), 32'd0);
    chk({tag, "_index"}, 32'(bus.index), 32'd0);
  endtask

  initial begin
    total         = 0;
    passed        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.select    = 1'b0;
    bus.number    = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_reset_vals("reset");

    frame("t1_max_tie", 4'b0000, 8'd3, 8'd9, 8'd9, 8'd1, 9, 1, 1'b0, 0);
    frame("t2_min_tie", 4'b1111, 8'd200, 8'd5, 8'd5, 8'd7, 5, 1, 1'b0, 0);
    frame("t3_sel_late", 4'b1110, 8'd10, 8'd20, 8'd30, 8'd40, 40, 3, 1'b0, 0);
    frame("t4_min_edge", 4'b1111, 8'd255, 8'd0, 8'd255, 8'd0, 0, 1, 1'b0, 0);
    frame("t4_max_edge", 4'b0000, 8'd255, 8'd0, 8'd255, 8'd0, 255, 0, 1'b0, 0);
    frame("t5_backpress", 4'b0000, 8'd12, 8'd34, 8'd56, 8'd21, 56, 2, 1'b0, 5);
    // A beat of 77 leaking in during HOLD would corrupt this frame.
    frame("t5_after", 4'b0000, 8'd1, 8'd2, 8'd3, 8'd4, 4, 3, 1'b0, 0);

    send(8'd99, 1'b0, "t6_partial0");
    send(8'd250, 1'b0, "t6_partial1");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("t6_midreset");
    frame("t6_fresh", 4'b0000, 8'd4, 8'd8, 8'd2, 8'd6, 8, 1, 1'b0, 0);

    send(8'd5, 1'b0, "t6_hold0");
    send(8'd6, 1'b0, "t6_hold1");
    send(8'd7, 1'b0, "t6_hold2");
    send(8'd8, 1'b0, "t6_hold3");
    chk("t6_hold_pending", 32'(bus.out_valid), 32'd1);
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    reset         = 1'b0;
    bus.out_ready = 1'b0;
    chk_reset_vals("t6_holdreset");

    frame("t6_gaps_min", 4'b1111, 8'd50, 8'd20, 8'd60, 8'd60, 20, 1, 1'b1, 0);
    frame("t6_gaps_max", 4'b0000, 8'd50, 8'd20, 8'd60, 8'd60, 60, 2, 1'b1, 0);

    frame("t6_b2b_a", 4'b1111, 8'd7, 8'd7, 8'd7, 8'd7, 7, 0, 1'b0, 0);
    frame("t6_b2b_b", 4'b0000, 8'd0, 8'd1, 8'd0, 8'd1, 1, 1, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
